// File: rtl/dmem_responder_pkg.sv
// Shared types and sizing for the data-memory responder and its byte packer.
package dmem_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        LOAD  = 2'd2
    } dmem_state_e;

    localparam int unsigned XLEN_DEFAULT   = 32;
    localparam int unsigned BYTES_PER_WORD = XLEN_DEFAULT / 8;

    // Lane-counter width for a given word width; never narrower than one bit.
    function automatic int unsigned bcnt_width(input int unsigned xlen);
        return (xlen / 8 > 1) ? $clog2(xlen / 8) : 1;
    endfunction

    localparam int unsigned BCNT_W = bcnt_width(XLEN_DEFAULT);

endpackage

// File: rtl/dmem_responder_byte_packer.sv
// Little-endian byte-to-word assembler for the loader stream; flags a word
// when its last lane fills or when the stream ends on a partial word.
module byte_packer
    import dmem_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            accept,
    input  logic [7:0]      byte_in,
    input  logic            last,
    output logic            word_valid,
    output logic [XLEN-1:0] word_data
);

    localparam int unsigned BPW = XLEN / 8;
    localparam int unsigned CW  = bcnt_width(XLEN);

    logic [CW-1:0]   byte_cnt;
    logic [XLEN-1:0] asm_q;
    logic [XLEN-1:0] lane;
    logic            full;

    assign full = (byte_cnt == CW'(BPW - 1));
    assign lane = XLEN'(byte_in) << {byte_cnt, 3'b000};

    // Lanes above byte_cnt are always zero, so the OR yields a zero-padded word.
    assign word_valid = accept && (full || last);
    assign word_data  = asm_q | lane;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt <= '0;
            asm_q    <= '0;
        end else if (accept) begin
            if (full || last) begin
                byte_cnt <= '0;
                asm_q    <= '0;
            end else begin
                byte_cnt <= byte_cnt + CW'(1);
                asm_q    <= asm_q | lane;
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core data port: self-clearing after reset,
// preloadable through a byte-stream loader, combinational reads.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] dmem_addr,
    inout  wire  [XLEN-1:0] dmem_data,
    input  logic            dmem_wen,
    output logic            busy,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [7:0]      ld_byte,
    input  logic            ld_last,
    output logic            ld_done
);

    dmem_state_e     state;
    logic [IDX_W-1:0] clr_ptr;
    logic [IDX_W-1:0] ld_ptr;
    logic             ld_done_q;
    logic [XLEN-1:0]  mem [DEPTH];

    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             word_valid;
    logic [XLEN-1:0]  word_data;
    logic             mem_we;
    logic [IDX_W-1:0] mem_idx;
    logic [XLEN-1:0]  mem_wdata;
    logic [XLEN-1:0]  rd_data;
    logic             unused_addr_bits;

    assign idx              = dmem_addr[IDX_W-1:0];
    assign unused_addr_bits = ^dmem_addr[XLEN-1:IDX_W];
    assign busy             = (state != IDLE);
    assign ld_ready         = (state == LOAD);
    assign accept           = ld_valid && ld_ready;
    assign ld_done          = ld_done_q;

    byte_packer #(.XLEN(XLEN)) u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .accept     (accept),
        .byte_in    (ld_byte),
        .last       (ld_last),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    // Single write port shared by the clear sweep, core stores and the loader.
    always_comb begin
        mem_we    = 1'b0;
        mem_idx   = idx;
        mem_wdata = dmem_data;
        case (state)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_idx   = clr_ptr;
                mem_wdata = '0;
            end
            IDLE: mem_we = dmem_wen;
            LOAD: begin
                mem_we    = word_valid;
                mem_idx   = ld_ptr;
                mem_wdata = word_data;
            end
            default: mem_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_idx] <= mem_wdata;
    end

    assign rd_data   = mem[idx];
    assign dmem_data = dmem_wen ? {XLEN{1'bz}} : (busy ? '0 : rd_data);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= CLEAR;
            clr_ptr   <= '0;
            ld_ptr    <= '0;
            ld_done_q <= 1'b0;
        end else begin
            ld_done_q <= 1'b0;
            case (state)
                CLEAR: begin
                    clr_ptr <= clr_ptr + IDX_W'(1);
                    if (clr_ptr == IDX_W'(DEPTH - 1)) state <= IDLE;
                end
                IDLE: begin
                    if (ld_valid) state <= LOAD;
                end
                LOAD: begin
                    if (accept && ld_last) begin
                        ld_ptr    <= '0;
                        ld_done_q <= 1'b1;
                        state     <= IDLE;
                    end else if (word_valid) begin
                        ld_ptr <= ld_ptr + IDX_W'(1);
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder: clear sweep, core writes,
// loader streams (bubbles, partial word, wrap) and reset abort.
module tb_dmem_responder;

    logic        clk;
    logic        reset_n;
    logic [31:0] dmem_addr;
    wire  [31:0] dmem_data;
    logic        dmem_wen;
    logic        busy;
    logic        ld_valid;
    logic        ld_ready;
    logic [7:0]  ld_byte;
    logic        ld_last;
    logic        ld_done;

    logic        tb_drive;
    logic [31:0] tb_wdata;

    assign dmem_data = tb_drive ? tb_wdata : 32'hzzzz_zzzz;

    dmem_responder #(.XLEN(32), .DEPTH(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .dmem_addr (dmem_addr),
        .dmem_data (dmem_data),
        .dmem_wen  (dmem_wen),
        .busy      (busy),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_byte   (ld_byte),
        .ld_last   (ld_last),
        .ld_done   (ld_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model[32];
    logic [31:0] words[33];
    int          total  = 0;
    int          passed = 0;
    int          fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr);
        exp_t e;
        sb.push_back('{tag, model[addr[4:0]]});
        @(negedge clk);
        dmem_addr = addr;
        #1;
        e = sb.pop_front();
        check(e.tag, dmem_data, e.data);
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < 32; i++) read_check($sformatf("%s_%0d", tag, i), 32'(i));
    endtask

    task automatic core_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        dmem_addr = addr;
        dmem_wen  = 1'b1;
        tb_drive  = 1'b1;
        tb_wdata  = data;
        #1;
        check("wr_released", dmem_data, data);
        @(negedge clk);
        dmem_wen = 1'b0;
        tb_drive = 1'b0;
    endtask

    // Offers one byte until the handshake completes (bounded); optional bubble after.
    task automatic send_byte(input logic [7:0] b, input logic last, input logic bubble);
        logic done;
        int   tries;
        done  = 1'b0;
        tries = 0;
        while (!done && tries < 8) begin
            @(negedge clk);
            ld_valid = 1'b1;
            ld_byte  = b;
            ld_last  = last;
            #1;
            done = ld_ready;
            @(posedge clk);
            tries++;
        end
        if (!done) check("ld_accept_timeout", {31'd0, done}, 32'd1);
        if (bubble || last) begin
            @(negedge clk);
            ld_valid = 1'b0;
            ld_last  = 1'b0;
        end
    endtask

    task automatic check_done_pulse(input string tag);
        int extra;
        #1;
        check({tag, "_done"}, {31'd0, ld_done}, 32'd1);
        check({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
        check({tag, "_ld_ptr"}, {27'd0, dut.ld_ptr}, 32'd0);
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            if (ld_done) extra++;
        end
        check({tag, "_done_once"}, 32'(extra), 32'd0);
    endtask

    task automatic count_busy(input string tag, input logic poke);
        int n;
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (poke && n == 5) begin
                dmem_addr = 32'd1;
                dmem_wen  = 1'b1;
                tb_drive  = 1'b1;
                tb_wdata  = 32'hFFFF_FFFF;
            end
            if (poke && n == 6) begin
                dmem_wen = 1'b0;
                tb_drive = 1'b0;
            end
            if (!busy) break;
        end
        check(tag, 32'(n), 32'd32);
    endtask

    initial begin
        reset_n   = 1'b0;
        dmem_addr = '0;
        dmem_wen  = 1'b0;
        ld_valid  = 1'b0;
        ld_byte   = '0;
        ld_last   = 1'b0;
        tb_drive  = 1'b0;
        tb_wdata  = '0;
        for (int i = 0; i < 32; i++) model[i] = '0;

        // Reset state and clear sweep
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
        check("rst_ld_done", {31'd0, ld_done}, 32'd0);
        check("rst_data_zero", dmem_data, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        count_busy("clear_cycles", 1'b0);
        read_all("clr");

        // Core write and aliased read
        core_write(32'd5, 32'hDEAD_BEEF);
        model[5] = 32'hDEAD_BEEF;
        read_check("raw_5", 32'd5);
        read_check("raw_alias_25", 32'h25);

        // 8-byte load with bubbles
        for (int i = 0; i < 8; i++)
            send_byte(8'((i + 1) * 8'h11), i == 7, i[0]);
        model[0] = 32'h4433_2211;
        model[1] = 32'h8877_6655;
        check_done_pulse("ld8");
        read_check("ld8_w0", 32'd0);
        read_check("ld8_w1", 32'd1);

        // 6-byte load entered together with a core write; stores during LOAD ignored
        @(negedge clk);
        ld_valid  = 1'b1;
        ld_byte   = 8'hA1;
        dmem_addr = 32'd12;
        dmem_wen  = 1'b1;
        tb_drive  = 1'b1;
        tb_wdata  = 32'h1234_5678;
        #1;
        check("idle_no_ready", {31'd0, ld_ready}, 32'd0);
        @(negedge clk);
        ld_valid = 1'b0;
        dmem_wen = 1'b0;
        tb_drive = 1'b0;
        model[12] = 32'h1234_5678;
        #1;
        check("load_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 3; i++) send_byte(8'(8'hA1 + i), 1'b0, 1'b1);
        core_write(32'd10, 32'hBAD0_BAD0);
        @(negedge clk);
        dmem_addr = 32'd12;
        #1;
        check("busy_read_zero", dmem_data, 32'd0);
        for (int i = 3; i < 6; i++) send_byte(8'(8'hA1 + i), i == 5, 1'b0);
        model[0] = 32'hA4A3_A2A1;
        model[1] = 32'h0000_A6A5;
        check_done_pulse("ld6");
        read_check("ld6_w0", 32'd0);
        read_check("ld6_w1", 32'd1);
        read_check("ld6_w10", 32'd10);
        read_check("ld6_w12", 32'd12);

        // 33-word load wraps back onto index 0
        for (int w = 0; w < 33; w++) begin
            words[w] = $urandom;
            for (int b = 0; b < 4; b++)
                send_byte(words[w][8*b +: 8], (w == 32) && (b == 3), $urandom_range(0, 3) == 0);
            model[w % 32] = words[w];
        end
        check_done_pulse("ld33");
        read_all("wrap");

        // Reset mid-load: partial word discarded, sweep restarts, stores ignored
        for (int i = 0; i < 3; i++) send_byte(8'(8'hC1 + i), 1'b0, 1'b1);
        @(negedge clk);
        reset_n  = 1'b0;
        ld_valid = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd1);
        check("abort_ready", {31'd0, ld_ready}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = '0;
        count_busy("reclear_cycles", 1'b1);
        read_all("reclr");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
